// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   RV32I instruction encoder and instruction-memory loader. Field-level
//   requests (class, registers, funct, immediate) arrive over valid/ready,
//   are encoded into 32-bit instruction words and buffered in a small FIFO.
//   The FIFO head is written to sequential imem word addresses starting at
//   BASE_ADDR. Requests that cannot be encoded are accepted and dropped,
//   and an error pulse with a code is raised instead.
//
// Parameters
//   DEPTH      output FIFO entries (power of 2, >= 2)
//   ADDR_W     imem word-address width
//   BASE_ADDR  first imem word address after reset/flush
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   flush                 empty the FIFO and reload imem_addr to BASE_ADDR
//   in_valid / in_ready   request handshake
//   in_cls                0 lw, 1 sw, 2 R, 3 B, 4 I-ALU, 5 jal, 6 lui, 7 reserved
//   in_rd/in_rs1/in_rs2   register fields
//   in_funct3, in_f7b5    funct3 and instruction bit 30
//   in_imm                signed byte offset / immediate (lui: full value)
//   imem_we / imem_ready  word handshake toward imem (imem_we = FIFO not empty)
//   imem_addr, imem_wdata current word address and FIFO head
//   err_valid, err_code   1-cycle drop pulse; code 1 class, 2 range, 3 misaligned
//   csum                  XOR of every popped word (only with ENC_CHECKSUM_EN)
//
// Configuration macro
//   ENC_CHECKSUM_EN  adds the csum output and its accumulator.
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_cls,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err_valid,
    output logic [1:0]        err_code
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [31:0]       csum
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_BRNCH = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [2:0] {
        CLS_LW, CLS_SW, CLS_R, CLS_B, CLS_IALU, CLS_JAL, CLS_LUI, CLS_RSVD
    } cls_e;

    typedef enum logic [1:0] {
        ERR_NONE, ERR_CLASS, ERR_RANGE, ERR_ALIGN
    } err_e;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic signed [31:0] imm_s;
    logic               is_shift;
    logic [31:0]        enc_word;
    err_e               enc_err;

    assign imm_s    = $signed(in_imm);
    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        enc_word = '0;
        enc_err  = ERR_NONE;
        case (cls_e'(in_cls))
            CLS_LW: begin
                enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
                if (imm_s < -2048 || imm_s > 2047) enc_err = ERR_RANGE;
            end
            CLS_SW: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
                if (imm_s < -2048 || imm_s > 2047) enc_err = ERR_RANGE;
            end
            CLS_R: begin
                enc_word = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_REG};
            end
            CLS_B: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], OP_BRNCH};
                // Alignment is reported ahead of range.
                if (in_imm[0])                           enc_err = ERR_ALIGN;
                else if (imm_s < -4096 || imm_s > 4094)  enc_err = ERR_RANGE;
            end
            CLS_IALU: begin
                if (is_shift) begin
                    // Shift immediates carry funct7 in imm[11:5] and shamt in imm[4:0].
                    enc_word = {1'b0, in_f7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IMM};
                    if (imm_s < 0 || imm_s > 31) enc_err = ERR_RANGE;
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
                    if (imm_s < -2048 || imm_s > 2047) enc_err = ERR_RANGE;
                end
            end
            CLS_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                if (in_imm[0])                                         enc_err = ERR_ALIGN;
                else if (imm_s < -(1 << 20) || imm_s > (1 << 20) - 2)  enc_err = ERR_RANGE;
            end
            CLS_LUI: begin
                enc_word = {in_imm[31:12], in_rd, OP_LUI};
                if (in_imm[11:0] != 12'h000) enc_err = ERR_RANGE;
            end
            default: enc_err = ERR_CLASS;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control, address counter, error reporting
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_valid_q, err_valid_d;
    err_e              err_code_q, err_code_d;
    logic [31:0]       mem_q [DEPTH];

    logic fifo_full, fifo_empty, accept, push, pop;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    // A full FIFO refuses a push even if it pops in the same cycle.
    assign in_ready   = !fifo_full && !flush;
    assign accept     = in_valid && in_ready;
    assign push       = accept && (enc_err == ERR_NONE);
    assign pop        = !fifo_empty && imem_ready && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_d      = addr_q;
        err_valid_d = accept && (enc_err != ERR_NONE);
        err_code_d  = (accept && (enc_err != ERR_NONE)) ? enc_err : err_code_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            addr_d   = BASE;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                addr_d   = addr_q + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= BASE;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the empty flag
    // guards every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= enc_word;
    end

    assign imem_we    = !fifo_empty;
    assign imem_wdata = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
    assign imem_addr  = addr_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;

`ifdef ENC_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (flush)    csum_d = '0;
        else if (pop) csum_d = csum_q ^ imem_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end

    assign csum = csum_q;
`endif

endmodule
